// File: rtl/counter_updown_mod.sv
// counter_updown_mod: parameterised up/down modulo counter with synchronous load,
// runtime inclusive upper limit, enable prescaler and wrap/saturate behaviour.
//
// Parameters
//   WIDTH     counter bit-width (>=1)
//   PRESCALE  enabled cycles per count step (>=1)
//   SATURATE  0 = wrap at limits, 1 = hold at limits
// Ports
//   clk         rising-edge clock
//   reset       synchronous reset, active high
//   enable      count enable; gates prescaler and stepping
//   dir         1 = count up, 0 = count down
//   load        synchronous load strobe (wins over stepping)
//   load_value  value loaded when load=1
//   max_value   inclusive upper limit, sampled every cycle
//   count       registered count value
//   wrap        registered 1-cycle pulse when a step crosses a limit
//   at_limit    registered: count==max_value (dir=1) or count==0 (dir=0)
module counter_updown_mod #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] max_value,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_limit
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]  ps_q;
  logic [PS_W-1:0]  ps_d;
  logic [WIDTH-1:0] count_d;
  logic             wrap_d;
  logic             at_limit_d;
  logic             step;

  // A step fires on the last enabled cycle of each prescale period.
  assign step = enable && (ps_q == PS_LAST);

  // Next-state: load beats step; a held counter never pulses wrap.
  always_comb begin
    ps_d       = ps_q;
    count_d    = count;
    wrap_d     = 1'b0;
    at_limit_d = 1'b0;

    if (load) begin
      count_d = load_value;
      ps_d    = '0;
    end else if (enable) begin
      if (step) begin
        ps_d = '0;
        if (dir) begin
          if (count >= max_value) begin
            count_d = SATURATE ? count : '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = count + WIDTH'(1);
          end
        end else begin
          // Zero check comes first so a saturating counter parks at 0.
          if (count == '0) begin
            count_d = SATURATE ? '0 : max_value;
            wrap_d  = 1'b1;
          end else if (count > max_value) begin
            count_d = max_value;
            wrap_d  = 1'b1;
          end else begin
            count_d = count - WIDTH'(1);
          end
        end
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end

    // Limit flag tracks the value being registered and the current direction.
    at_limit_d = dir ? (count_d == max_value) : (count_d == '0);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q     <= '0;
      count    <= '0;
      wrap     <= 1'b0;
      at_limit <= 1'b0;
    end else begin
      ps_q     <= ps_d;
      count    <= count_d;
      wrap     <= wrap_d;
      at_limit <= at_limit_d;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Testbench for counter_updown_mod: three 4-bit instances (wrap, saturate,
// prescale-by-3) share one stimulus stream; expected {count,wrap,at_limit}
// triples are queued when stimulus is driven and popped after the edge.
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic [3:0] max_value = 4'd0;

  logic [3:0] cnt_w, cnt_s, cnt_p;
  logic       wrap_w, wrap_s, wrap_p;
  logic       al_w, al_s, al_p;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] q_w[$];
  logic [5:0] q_s[$];
  logic [5:0] q_p[$];

  wire [5:0] obs_w = {cnt_w, wrap_w, al_w};
  wire [5:0] obs_s = {cnt_s, wrap_s, al_s};
  wire [5:0] obs_p = {cnt_p, wrap_p, al_p};

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(4), .PRESCALE(1), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .load(load),
    .load_value(load_value), .max_value(max_value),
    .count(cnt_w), .wrap(wrap_w), .at_limit(al_w));

  counter_updown_mod #(.WIDTH(4), .PRESCALE(1), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .load(load),
    .load_value(load_value), .max_value(max_value),
    .count(cnt_s), .wrap(wrap_s), .at_limit(al_s));

  counter_updown_mod #(.WIDTH(4), .PRESCALE(3), .SATURATE(1'b0)) u_ps (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .load(load),
    .load_value(load_value), .max_value(max_value),
    .count(cnt_p), .wrap(wrap_p), .at_limit(al_p));

  // Apply one cycle of stimulus on the falling edge.
  task automatic set_in(input logic r, input logic e, input logic d, input logic l,
                        input logic [3:0] lv, input logic [3:0] mx);
    @(negedge clk);
    reset = r; enable = e; dir = d; load = l; load_value = lv; max_value = mx;
  endtask

  task automatic test_reset;
    logic [5:0] e;
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 4'd3);
    @(posedge clk);
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 4'd11, 4'd2);
    q_w.push_back(6'b0); q_s.push_back(6'b0); q_p.push_back(6'b0);
    @(posedge clk); #1;
    e = q_w.pop_front(); n_checks++;
    if (obs_w !== e) begin n_fail++; $display("FAIL reset u_wrap: got %b expected %b", obs_w, e); end
    e = q_s.pop_front(); n_checks++;
    if (obs_s !== e) begin n_fail++; $display("FAIL reset u_sat: got %b expected %b", obs_s, e); end
    e = q_p.pop_front(); n_checks++;
    if (obs_p !== e) begin n_fail++; $display("FAIL reset u_ps: got %b expected %b", obs_p, e); end
  endtask

  // Up from 0 with max 9: 1..9, 0 with wrap, 1. Saturating copy parks at 9.
  task automatic test_up_wrap;
    logic [5:0] e;
    for (int k = 1; k <= 11; k++) begin
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9);
      q_w.push_back({4'(k % 10), k == 10, (k % 10) == 9});
      q_s.push_back({(k >= 9) ? 4'd9 : 4'(k), k >= 10, k >= 9});
      @(posedge clk); #1;
      e = q_w.pop_front(); n_checks++;
      if (obs_w !== e) begin n_fail++; $display("FAIL up_wrap[%0d] u_wrap: got %b expected %b", k, obs_w, e); end
      e = q_s.pop_front(); n_checks++;
      if (obs_s !== e) begin n_fail++; $display("FAIL up_sat[%0d] u_sat: got %b expected %b", k, obs_s, e); end
    end
  endtask

  // Load 2, then count down with max 9.
  task automatic test_down_wrap;
    logic [5:0] e;
    logic [5:0] exp_w[4] = '{{4'd1, 2'b00}, {4'd0, 2'b01}, {4'd9, 2'b10}, {4'd8, 2'b00}};
    logic [5:0] exp_s[4] = '{{4'd1, 2'b00}, {4'd0, 2'b01}, {4'd0, 2'b11}, {4'd0, 2'b11}};
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd9);
    q_w.push_back({4'd2, 2'b00});
    @(posedge clk); #1;
    e = q_w.pop_front(); n_checks++;
    if (obs_w !== e) begin n_fail++; $display("FAIL down_load u_wrap: got %b expected %b", obs_w, e); end
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9);
      q_w.push_back(exp_w[k]); q_s.push_back(exp_s[k]);
      @(posedge clk); #1;
      e = q_w.pop_front(); n_checks++;
      if (obs_w !== e) begin n_fail++; $display("FAIL down_wrap[%0d] u_wrap: got %b expected %b", k, obs_w, e); end
      e = q_s.pop_front(); n_checks++;
      if (obs_s !== e) begin n_fail++; $display("FAIL down_sat[%0d] u_sat: got %b expected %b", k, obs_s, e); end
    end
  endtask

  // PRESCALE=3: steps on 3rd and 6th enabled cycle; a gap does not lose phase.
  task automatic test_prescale;
    logic [5:0] e;
    logic       en_pat[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp_c[7]  = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd9);
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      set_in(1'b0, en_pat[k], 1'b1, 1'b0, 4'd0, 4'd9);
      q_p.push_back({exp_c[k], 2'b00});
      @(posedge clk); #1;
      e = q_p.pop_front(); n_checks++;
      if (obs_p !== e) begin n_fail++; $display("FAIL prescale[%0d] u_ps: got %b expected %b", k, obs_p, e); end
    end
  endtask

  // Load over step, then up/down steps from a count above max; load clears ps.
  task automatic test_load_priority;
    logic [5:0] e;
    logic       st_dir[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       st_ld[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [5:0] exp_w[6]  = '{{4'd12, 2'b00}, {4'd0, 2'b10}, {4'd12, 2'b00},
                              {4'd9, 2'b10}, {4'd8, 2'b00}, {4'd7, 2'b00}};
    logic [5:0] exp_s[6]  = '{{4'd12, 2'b00}, {4'd12, 2'b10}, {4'd12, 2'b00},
                              {4'd9, 2'b10}, {4'd8, 2'b00}, {4'd7, 2'b00}};
    logic [5:0] exp_p[6]  = '{{4'd12, 2'b00}, {4'd12, 2'b00}, {4'd12, 2'b00},
                              {4'd12, 2'b00}, {4'd12, 2'b00}, {4'd9, 2'b10}};
    for (int k = 0; k < 6; k++) begin
      set_in(1'b0, 1'b1, st_dir[k], st_ld[k], 4'd12, 4'd9);
      q_w.push_back(exp_w[k]); q_s.push_back(exp_s[k]); q_p.push_back(exp_p[k]);
      @(posedge clk); #1;
      e = q_w.pop_front(); n_checks++;
      if (obs_w !== e) begin n_fail++; $display("FAIL load_prio[%0d] u_wrap: got %b expected %b", k, obs_w, e); end
      e = q_s.pop_front(); n_checks++;
      if (obs_s !== e) begin n_fail++; $display("FAIL load_prio[%0d] u_sat: got %b expected %b", k, obs_s, e); end
      e = q_p.pop_front(); n_checks++;
      if (obs_p !== e) begin n_fail++; $display("FAIL load_prio[%0d] u_ps: got %b expected %b", k, obs_p, e); end
    end
  endtask

  // Reset with load and a pending prescaled step clears everything.
  task automatic test_reset_mid;
    logic [5:0] e;
    logic [3:0] exp_p[3] = '{4'd0, 4'd0, 4'd1};
    repeat (2) begin
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9);
      @(posedge clk);
    end
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 4'd9);
    q_w.push_back(6'b0); q_p.push_back(6'b0);
    @(posedge clk); #1;
    e = q_w.pop_front(); n_checks++;
    if (obs_w !== e) begin n_fail++; $display("FAIL reset_mid u_wrap: got %b expected %b", obs_w, e); end
    e = q_p.pop_front(); n_checks++;
    if (obs_p !== e) begin n_fail++; $display("FAIL reset_mid u_ps: got %b expected %b", obs_p, e); end
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9);
      q_p.push_back({exp_p[k], 2'b00});
      q_w.push_back({4'(k + 1), 2'b00});
      @(posedge clk); #1;
      e = q_p.pop_front(); n_checks++;
      if (obs_p !== e) begin n_fail++; $display("FAIL reset_phase[%0d] u_ps: got %b expected %b", k, obs_p, e); end
      e = q_w.pop_front(); n_checks++;
      if (obs_w !== e) begin n_fail++; $display("FAIL reset_count[%0d] u_wrap: got %b expected %b", k, obs_w, e); end
    end
  endtask

  // max_value=0 from count 3: every step lands on 0 with wrap (saturating holds 3 going up).
  task automatic test_max_zero;
    logic [5:0] e;
    logic       st_dir[3] = '{1'b1, 1'b1, 1'b0};
    logic [5:0] exp_s[3]  = '{{4'd3, 2'b10}, {4'd3, 2'b10}, {4'd0, 2'b11}};
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, 1'b1, st_dir[k], 1'b0, 4'd0, 4'd0);
      q_w.push_back({4'd0, 2'b11}); q_s.push_back(exp_s[k]);
      @(posedge clk); #1;
      e = q_w.pop_front(); n_checks++;
      if (obs_w !== e) begin n_fail++; $display("FAIL max_zero[%0d] u_wrap: got %b expected %b", k, obs_w, e); end
      e = q_s.pop_front(); n_checks++;
      if (obs_s !== e) begin n_fail++; $display("FAIL max_zero[%0d] u_sat: got %b expected %b", k, obs_s, e); end
    end
  endtask

  // Holding count: dir and max_value changes alone move at_limit; wrap stays low.
  task automatic test_limit_flag;
    logic [5:0] e;
    logic       st_ld[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic       st_dir[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] st_mx[4]  = '{4'd9, 4'd9, 4'd9, 4'd8};
    logic [5:0] exp_w[4]  = '{{4'd9, 2'b01}, {4'd9, 2'b00}, {4'd9, 2'b01}, {4'd9, 2'b00}};
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 1'b0, st_dir[k], st_ld[k], 4'd9, st_mx[k]);
      q_w.push_back(exp_w[k]);
      @(posedge clk); #1;
      e = q_w.pop_front(); n_checks++;
      if (obs_w !== e) begin n_fail++; $display("FAIL limit_flag[%0d] u_wrap: got %b expected %b", k, obs_w, e); end
    end
  endtask

  // max_value=15: random enable/dir against a plain 4-bit binary counter.
  task automatic test_binary_random;
    logic [5:0] e;
    logic [3:0] c, nc;
    logic       en, d, wr, al;
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd15);
    @(posedge clk);
    c = 4'd0;
    for (int k = 0; k < 40; k++) begin
      en = 1'($urandom_range(0, 3) != 0);
      d  = 1'($urandom_range(0, 1));
      set_in(1'b0, en, d, 1'b0, 4'd0, 4'd15);
      nc = en ? (d ? c + 4'd1 : c - 4'd1) : c;
      wr = en && (d ? (c == 4'd15) : (c == 4'd0));
      al = d ? (nc == 4'd15) : (nc == 4'd0);
      q_w.push_back({nc, wr, al});
      c = nc;
      @(posedge clk); #1;
      e = q_w.pop_front(); n_checks++;
      if (obs_w !== e) begin n_fail++; $display("FAIL binary[%0d] u_wrap: got %b expected %b", k, obs_w, e); end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_prescale();
    test_load_priority();
    test_reset_mid();
    test_max_zero();
    test_limit_flag();
    test_binary_random();
    n_checks++;
    if ((q_w.size() + q_s.size() + q_p.size()) != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0",
               q_w.size() + q_s.size() + q_p.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
